// File: rtl/fifo_ctrl.sv
// Pointer/flag controller turning a dual-port register file into a FIFO.
// Optional sticky overflow/underflow flags: define FIFO_CTRL_ERR_EN.
module fifo_ctrl #(
   parameter int Awidth   = 2,
   parameter int AF_LEVEL = 3,
   parameter int AE_LEVEL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr,
   input  logic              rd,
`ifdef FIFO_CTRL_ERR_EN
   input  logic              err_clr,
   output logic              overflow,
   output logic              underflow,
`endif
   output logic              wren,
   output logic [Awidth-1:0] waddr,
   output logic [Awidth-1:0] raddr,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic [Awidth:0]   count
);

   localparam int DEPTH = 2**Awidth;
   localparam logic [Awidth:0]   DepthC = (Awidth+1)'(DEPTH);
   localparam logic [Awidth:0]   AfC    = (Awidth+1)'(AF_LEVEL);
   localparam logic [Awidth:0]   AeC    = (Awidth+1)'(AE_LEVEL);
   localparam logic [Awidth-1:0] PtrOne = Awidth'(1);
   localparam logic [Awidth:0]   CntOne = (Awidth+1)'(1);

   logic [Awidth-1:0] w_ptr_q, w_ptr_d;
   logic [Awidth-1:0] r_ptr_q, r_ptr_d;
   logic [Awidth:0]   cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              push_ok, pop_ok;

   // A push into a full FIFO is legal when a pop frees the slot this edge.
   assign push_ok = wr & (~full_q | rd);
   assign pop_ok  = rd & ~empty_q;

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      cnt_d   = cnt_q;
      if (push_ok) w_ptr_d = w_ptr_q + PtrOne;
      if (pop_ok)  r_ptr_d = r_ptr_q + PtrOne;
      unique case (1'b1)
         push_ok & ~pop_ok: cnt_d = cnt_q + CntOne;
         pop_ok & ~push_ok: cnt_d = cnt_q - CntOne;
         default: ;
      endcase
      full_d  = (cnt_d == DepthC);
      empty_d = (cnt_d == '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

`ifdef FIFO_CTRL_ERR_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // A new error in the same cycle as err_clr keeps the flag set.
   assign ovf_d = (ovf_q & ~err_clr) | (wr & full_q & ~rd);
   assign unf_d = (unf_q & ~err_clr) | (rd & empty_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

   assign wren         = push_ok;
   assign waddr        = w_ptr_q;
   assign raddr        = r_ptr_q;
   assign full         = full_q;
   assign empty        = empty_q;
   assign count        = cnt_q;
   assign almost_full  = (cnt_q >= AfC);
   assign almost_empty = (cnt_q <= AeC);

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural register file.
// Error-flag checks are compiled in when FIFO_CTRL_ERR_EN is defined.
module tb_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr, rd;
   logic       wren;
   logic [1:0] waddr, raddr;
   logic       full, empty, almost_full, almost_empty;
   logic [2:0] count;
   logic [7:0] wdata;
   logic [7:0] mem [4];
`ifdef FIFO_CTRL_ERR_EN
   logic       err_clr;
   logic       overflow, underflow;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   fifo_ctrl #(.Awidth(2), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr          (wr),
      .rd          (rd),
`ifdef FIFO_CTRL_ERR_EN
      .err_clr     (err_clr),
      .overflow    (overflow),
      .underflow   (underflow),
`endif
      .wren        (wren),
      .waddr       (waddr),
      .raddr       (raddr),
      .full        (full),
      .empty       (empty),
      .almost_full (almost_full),
      .almost_empty(almost_empty),
      .count       (count)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (wren) mem[waddr] <= wdata;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r);
      wr = w;
      rd = r;
      #1;
   endtask

   task automatic do_reset();
      wr = 1'b0;
      rd = 1'b0;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_count"}, int'(count), 0);
      chk({tag, "_empty"}, int'(empty), 1);
      chk({tag, "_full"}, int'(full), 0);
      chk({tag, "_ae"}, int'(almost_empty), 1);
      chk({tag, "_af"}, int'(almost_full), 0);
      chk({tag, "_waddr"}, int'(waddr), 0);
      chk({tag, "_raddr"}, int'(raddr), 0);
   endtask

   initial begin
      wr = 1'b0;
      rd = 1'b0;
      wdata = 8'h00;
      rst_n = 1'b0;
`ifdef FIFO_CTRL_ERR_EN
      err_clr = 1'b0;
`endif
      #12;
      rst_n = 1'b1;
      #1;
      chk_idle("rst");
      cyc();
      chk_idle("idle");

      for (int i = 0; i < 4; i++) begin
         wdata = 8'h10 + 8'(i);
         drive(1'b1, 1'b0);
         chk("push_wren", int'(wren), 1);
         cyc();
         chk("push_count", int'(count), i + 1);
         chk("push_af", int'(almost_full), int'(i + 1 >= 3));
         chk("push_ae", int'(almost_empty), int'(i + 1 <= 1));
         chk("push_full", int'(full), int'(i == 3));
         chk("push_empty", int'(empty), 0);
         chk("push_waddr", int'(waddr), (i + 1) % 4);
      end

      drive(1'b1, 1'b0);
      chk("ovf_wren", int'(wren), 0);
      cyc();
      chk("ovf_waddr", int'(waddr), 0);
      chk("ovf_count", int'(count), 4);
      chk("ovf_full", int'(full), 1);
`ifdef FIFO_CTRL_ERR_EN
      chk("ovf_flag", int'(overflow), 1);
      drive(1'b0, 1'b0);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      chk("ovf_clr", int'(overflow), 0);
`endif

      for (int i = 0; i < 3; i++) begin
         wdata = 8'h20 + 8'(i);
         drive(1'b1, 1'b1);
         chk("fullrw_wren", int'(wren), 1);
         cyc();
         chk("fullrw_full", int'(full), 1);
         chk("fullrw_count", int'(count), 4);
         chk("fullrw_waddr", int'(waddr), i + 1);
         chk("fullrw_raddr", int'(raddr), i + 1);
      end

      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1);
         cyc();
         chk("drain_count", int'(count), 3 - i);
         chk("drain_raddr", int'(raddr), (i + 4) % 4);
      end
      chk("drain_empty", int'(empty), 1);

      do_reset();
      chk_idle("rst2");
      wdata = 8'h55;
      drive(1'b1, 1'b1);
      chk("emptyrw_wren", int'(wren), 1);
      cyc();
      chk("emptyrw_count", int'(count), 1);
      chk("emptyrw_empty", int'(empty), 0);
      chk("emptyrw_raddr", int'(raddr), 0);
      chk("emptyrw_data", int'(mem[raddr]), 8'h55);
      drive(1'b0, 1'b1);
      cyc();
      chk("pop1_count", int'(count), 0);
      chk("pop1_empty", int'(empty), 1);
      chk("pop1_raddr", int'(raddr), 1);
      drive(1'b0, 1'b1);
      cyc();
      chk("unf_raddr", int'(raddr), 1);
      chk("unf_count", int'(count), 0);
`ifdef FIFO_CTRL_ERR_EN
      chk("unf_flag", int'(underflow), 1);
      err_clr = 1'b1;
      cyc();
      chk("unf_setwins", int'(underflow), 1);
      drive(1'b0, 1'b0);
      cyc();
      err_clr = 1'b0;
      chk("unf_clr", int'(underflow), 0);
`endif

      do_reset();
      for (int i = 0; i < 6; i++) begin
         wdata = 8'hA0 + 8'(i);
         drive(1'b1, 1'b0);
         chk("wrap_waddr", int'(waddr), i % 4);
         cyc();
         drive(1'b0, 1'b1);
         chk("wrap_raddr", int'(raddr), i % 4);
         chk("wrap_data", int'(mem[raddr]), 8'hA0 + i);
         cyc();
         chk("wrap_empty", int'(empty), 1);
      end

      drive(1'b1, 1'b0);
      cyc();
      cyc();
      drive(1'b0, 1'b0);
      chk("pre_arst_count", int'(count), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_idle("arst");
      rst_n = 1'b1;
      cyc();
      chk_idle("post_arst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
